// File: rtl/frame_reception.sv
// frame_reception: byte-wide Ethernet frame receiver.
// Hunts for preamble (0xAA...) and SFD (0xAB), then parses destination,
// source, EtherType, a 4-byte payload and a 4-byte FCS. A reflected CRC-32
// over destination..payload is compared against the received FCS.
// Optional feature macro: RX_ADDR_FILTER_EN (drop frames whose destination
// is neither MAC_ADDR nor broadcast).
module frame_reception #(
    parameter int          PREAMBLE_MIN = 7,
    parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_in,
    input  logic        rx_dv,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [15:0] eth_type,
    output logic [31:0] data_out,
    output logic        rx_done,
    output logic        crc_ok,
    output logic        rx_abort
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DEST, S_SRC, S_TYPE, S_PAYLOAD, S_FCS, S_DRAIN
    } state_t;

    localparam logic [3:0]  PRE_MIN  = 4'(PREAMBLE_MIN);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    // Reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320), LSB of byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [47:0] dest_w_q, dest_w_d;
    logic [47:0] src_w_q, src_w_d;
    logic [15:0] type_w_q, type_w_d;
    logic [31:0] data_w_q, data_w_d;
    logic [23:0] fcs_w_q, fcs_w_d;
    logic [47:0] dest_addr_q, dest_addr_d;
    logic [47:0] src_addr_q, src_addr_d;
    logic [15:0] eth_type_q, eth_type_d;
    logic [31:0] data_out_q, data_out_d;
    logic        rx_done_q, rx_done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        rx_abort_q, rx_abort_d;

    logic [47:0] dest_full;
    logic [31:0] fcs_full;
    logic        addr_ok;

    // Destination filter decision on the completed 6-byte address.
    always_comb begin
        dest_full = {dest_w_q[39:0], rx_in};
`ifdef RX_ADDR_FILTER_EN
        addr_ok = (dest_full == MAC_ADDR) || (dest_full == 48'hFFFF_FFFF_FFFF);
`else
        // No filtering: every destination is accepted; the comparison keeps
        // MAC_ADDR referenced so both builds share one parameter list.
        addr_ok = (dest_full == MAC_ADDR) | 1'b1;
`endif
    end

    // Next-state, field shifting, CRC update and strobe generation.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        dest_w_d    = dest_w_q;
        src_w_d     = src_w_q;
        type_w_d    = type_w_q;
        data_w_d    = data_w_q;
        fcs_w_d     = fcs_w_q;
        dest_addr_d = dest_addr_q;
        src_addr_d  = src_addr_q;
        eth_type_d  = eth_type_q;
        data_out_d  = data_out_q;
        rx_done_d   = 1'b0;
        crc_ok_d    = 1'b0;
        rx_abort_d  = 1'b0;
        fcs_full    = {fcs_w_q, rx_in};

        case (state_q)
            S_IDLE: begin
                pre_cnt_d  = 4'd0;
                byte_cnt_d = 3'd0;
                crc_d      = CRC_INIT;
                if (rx_dv && rx_in == 8'hAA) begin
                    pre_cnt_d = 4'd1;
                    state_d   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                crc_d = CRC_INIT;
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_in == 8'hAA) begin
                    if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (rx_in == 8'hAB && pre_cnt_q >= PRE_MIN) begin
                    byte_cnt_d = 3'd0;
                    state_d    = S_DEST;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DEST, S_SRC, S_TYPE, S_PAYLOAD, S_FCS: begin
                if (!rx_dv) begin
                    // Gap inside a frame: truncated, outputs untouched.
                    rx_abort_d = 1'b1;
                    byte_cnt_d = 3'd0;
                    state_d    = S_IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (state_q != S_FCS) crc_d = crc32_byte(crc_q, rx_in);
                    case (state_q)
                        S_DEST: begin
                            dest_w_d = dest_full;
                            if (byte_cnt_q == 3'd5) begin
                                byte_cnt_d = 3'd0;
                                state_d    = addr_ok ? S_SRC : S_DRAIN;
                            end
                        end
                        S_SRC: begin
                            src_w_d = {src_w_q[39:0], rx_in};
                            if (byte_cnt_q == 3'd5) begin
                                byte_cnt_d = 3'd0;
                                state_d    = S_TYPE;
                            end
                        end
                        S_TYPE: begin
                            type_w_d = {type_w_q[7:0], rx_in};
                            if (byte_cnt_q == 3'd1) begin
                                byte_cnt_d = 3'd0;
                                state_d    = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            data_w_d = {data_w_q[23:0], rx_in};
                            if (byte_cnt_q == 3'd3) begin
                                byte_cnt_d = 3'd0;
                                state_d    = S_FCS;
                            end
                        end
                        S_FCS: begin
                            fcs_w_d = fcs_full[23:0];
                            if (byte_cnt_q == 3'd3) begin
                                // Frame complete; trailing bytes are drained.
                                byte_cnt_d  = 3'd0;
                                state_d     = S_DRAIN;
                                rx_done_d   = 1'b1;
                                crc_ok_d    = (fcs_full == ~crc_q);
                                dest_addr_d = dest_w_q;
                                src_addr_d  = src_w_q;
                                eth_type_d  = type_w_q;
                                data_out_d  = data_w_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DRAIN: begin
                byte_cnt_d = 3'd0;
                crc_d      = CRC_INIT;
                if (!rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, working and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= 4'd0;
            byte_cnt_q  <= 3'd0;
            crc_q       <= CRC_INIT;
            dest_w_q    <= 48'd0;
            src_w_q     <= 48'd0;
            type_w_q    <= 16'd0;
            data_w_q    <= 32'd0;
            fcs_w_q     <= 24'd0;
            dest_addr_q <= 48'd0;
            src_addr_q  <= 48'd0;
            eth_type_q  <= 16'd0;
            data_out_q  <= 32'd0;
            rx_done_q   <= 1'b0;
            crc_ok_q    <= 1'b0;
            rx_abort_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            dest_w_q    <= dest_w_d;
            src_w_q     <= src_w_d;
            type_w_q    <= type_w_d;
            data_w_q    <= data_w_d;
            fcs_w_q     <= fcs_w_d;
            dest_addr_q <= dest_addr_d;
            src_addr_q  <= src_addr_d;
            eth_type_q  <= eth_type_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            crc_ok_q    <= crc_ok_d;
            rx_abort_q  <= rx_abort_d;
        end
    end

    assign dest_addr = dest_addr_q;
    assign src_addr  = src_addr_q;
    assign eth_type  = eth_type_q;
    assign data_out  = data_out_q;
    assign rx_done   = rx_done_q;
    assign crc_ok    = crc_ok_q;
    assign rx_abort  = rx_abort_q;

endmodule

// File: tb/tb_frame_reception.sv
// Testbench for frame_reception: directed frames with constant expected
// fields and a bench-side CRC-32 used to build the FCS bytes.
module tb_frame_reception;

    localparam logic [47:0] D0 = 48'h0200_0000_0001;
    localparam logic [47:0] D1 = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] S0 = 48'h1122_3344_5566;
    localparam logic [47:0] S1 = 48'hA1A2_A3A4_A5A6;
    localparam logic [15:0] T0 = 16'h0800;
    localparam logic [15:0] T1 = 16'h86DD;
    localparam logic [31:0] P0 = 32'hDEAD_BEEF;
    localparam logic [31:0] P1 = 32'hCAFE_F00D;
    localparam logic [31:0] P2 = 32'h0123_4567;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_in;
    logic        rx_dv;
    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic [31:0] data_out;
    logic        rx_done;
    logic        crc_ok;
    logic        rx_abort;

    int checks    = 0;
    int errors    = 0;
    int abort_cnt = 0;

    logic [7:0]  frame_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] sb_e;

    frame_reception dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_dv     (rx_dv),
        .dest_addr (dest_addr),
        .src_addr  (src_addr),
        .eth_type  (eth_type),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .crc_ok    (crc_ok),
        .rx_abort  (rx_abort)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
            else      r = r >> 1;
        end
        return r;
    endfunction

    // Builds 18 header/payload bytes plus 4 FCS bytes into frame_q.
    task automatic build_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input logic [31:0] p,
                               input logic [7:0] fcs_xor);
        logic [31:0] c;
        logic [31:0] fcs;
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(s[i*8 +: 8]);
        for (int i = 1; i >= 0; i--) frame_q.push_back(t[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frame_q.push_back(p[i*8 +: 8]);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 18; i++) c = crc_step(c, frame_q[i]);
        fcs = ~c;
        frame_q.push_back(fcs[31:24]);
        frame_q.push_back(fcs[23:16]);
        frame_q.push_back(fcs[15:8]);
        frame_q.push_back(fcs[7:0] ^ fcs_xor);
    endtask

    // Drivers
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_in = b;
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_dv = 1'b0;
        rx_in = 8'h00;
    endtask

    task automatic send_frame(input int pre_n, input int nbytes);
        for (int i = 0; i < pre_n; i++) send_byte(8'hAA);
        send_byte(8'hAB);
        for (int i = 0; i < nbytes; i++) send_byte(frame_q[i]);
    endtask

    // Call right after the last FCS byte is driven.
    task automatic expect_done(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input logic [31:0] p,
                               input logic ok, input int extra);
        exp_q.push_back({ok, p});
        @(posedge clk);
        #1;
        check_eq("done_strobe", rx_done, 1'b1);
        check_eq("crc_ok", crc_ok, ok);
        check_eq("dest_addr", dest_addr, d);
        check_eq("src_addr", src_addr, s);
        check_eq("eth_type", eth_type, t);
        check_eq("data_out", data_out, p);
        for (int i = 0; i < extra; i++) send_byte(8'hAA);
        end_frame();
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", rx_done, 1'b0);
        check_eq("crc_ok_one_cycle", crc_ok, 1'b0);
    endtask

    // Scoreboard: every completion must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rx_done) begin
            check_eq("sb_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check_eq("sb_done", {crc_ok, data_out}, sb_e);
            end
        end
        if (rx_abort) abort_cnt++;
    end

    initial begin
        int lens[2];
        lens[0] = 5;
        lens[1] = 6;
        rst   = 1'b1;
        rx_dv = 1'b0;
        rx_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dest", dest_addr, 48'd0);
        check_eq("rst_src", src_addr, 48'd0);
        check_eq("rst_type", eth_type, 16'd0);
        check_eq("rst_data", data_out, 32'd0);
        check_eq("rst_done", rx_done, 1'b0);
        check_eq("rst_crc_ok", crc_ok, 1'b0);
        check_eq("rst_abort", rx_abort, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame, minimum preamble
        build_frame(D0, S0, T0, P0, 8'h00);
        send_frame(7, 22);
        expect_done(D0, S0, T0, P0, 1'b1, 0);

        // Corrupted FCS: strobe still fires, fields still update
        build_frame(D0, S0, T0, P1, 8'h01);
        send_frame(7, 22);
        expect_done(D0, S0, T0, P1, 1'b0, 0);

        // Short preambles are drained without any strobe
        for (int n = 0; n < 2; n++) begin
            build_frame(D1, S1, T1, P2, 8'h00);
            send_frame(lens[n], 22);
            end_frame();
            repeat (2) @(posedge clk);
            #1;
            check_eq("short_pre_data_held", data_out, P1);
            check_eq("short_pre_no_abort", abort_cnt, 0);
        end
        build_frame(D0, S0, T0, P0, 8'h00);
        send_frame(7, 22);
        expect_done(D0, S0, T0, P0, 1'b1, 0);

        // Abort after third source byte
        build_frame(D1, S1, T1, P2, 8'h00);
        send_frame(7, 9);
        end_frame();
        @(posedge clk);
        #1;
        check_eq("abort_strobe", rx_abort, 1'b1);
        check_eq("abort_no_done", rx_done, 1'b0);
        @(posedge clk);
        #1;
        check_eq("abort_one_cycle", rx_abort, 1'b0);
        check_eq("abort_src_held", src_addr, S0);
        check_eq("abort_data_held", data_out, P0);
        check_eq("abort_count", abort_cnt, 1);

        // Reset in the middle of the payload
        build_frame(D1, S1, T1, P2, 8'h00);
        send_frame(7, 16);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        rx_dv = 1'b0;
        #1;
        check_eq("midrst_dest", dest_addr, 48'd0);
        check_eq("midrst_src", src_addr, 48'd0);
        check_eq("midrst_type", eth_type, 16'd0);
        check_eq("midrst_data", data_out, 32'd0);
        check_eq("midrst_done", rx_done, 1'b0);
        check_eq("midrst_abort", rx_abort, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        build_frame(D1, S1, T1, P2, 8'h00);
        send_frame(7, 22);
        expect_done(D1, S1, T1, P2, 1'b1, 0);
        check_eq("midrst_abort_count", abort_cnt, 1);

        // Long preamble (counter saturates) with trailing bytes after FCS
        build_frame(D0, S1, T0, P1, 8'h00);
        send_frame(20, 22);
        expect_done(D0, S1, T0, P1, 1'b1, 3);

`ifdef RX_ADDR_FILTER_EN
        // Foreign destination is dropped silently
        build_frame(48'h0A0B_0C0D_0E0F, S0, T0, P0, 8'h00);
        send_frame(7, 22);
        end_frame();
        repeat (2) @(posedge clk);
        #1;
        check_eq("filt_data_held", data_out, P1);
        check_eq("filt_no_abort", abort_cnt, 1);
        // Broadcast is accepted
        build_frame(D1, S0, T0, P0, 8'h00);
        send_frame(7, 22);
        expect_done(D1, S0, T0, P0, 1'b1, 0);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        check_eq("final_abort_count", abort_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
